mrv1_ifetch: RTL and testbench
==============================

// Module: mrv1_ifetch
// PURPOSE
//  Instruction-fetch front end driven by the IMT scheduler: accepts {tid,pc} issues, sends in-order imem requests,
//  matches responses and hands {tid,pc,instr} to decode. Reports fetch_done back to the scheduler to release the
//  per-thread fetch lock and advance the thread PC. Supports per-thread flush on redirect.
// PARAMETERS
//  NUM_TW_P       8   number of thread/warps; request queue (RQ) depth
//  RSP_Q_DEPTH_P  4   max outstanding imem requests + buffered responses (power of 2, >=2)
//  tid_width_lp   $clog2(NUM_TW_P)  local, thread-id width
// PORTS
//  clk_i            in   1     clock
//  rst_ni           in   1     synchronous reset, active-low
//  sched_vld_i      in   1     scheduler issue valid (no backpressure)
//  sched_tid_i      in   TIDW  issued thread id
//  sched_pc_i       in   32    issued PC
//  flush_vld_i      in   1     kill all older fetches of flush_tid_i
//  flush_tid_i      in   TIDW  thread to flush
//  imem_req_vld_o   out  1     memory request valid
//  imem_req_addr_o  out  32    request address
//  imem_req_rdy_i   in   1     memory accepts request
//  imem_rsp_vld_i   in   1     in-order response valid (always accepted)
//  imem_rsp_data_i  in   32    instruction word
//  dec_vld_o/dec_rdy_i  out/in 1  decode handshake
//  dec_tid_o/dec_pc_o/dec_instr_o  out  TIDW/32/32  decode payload
//  fetch_done_o     out  1     pulse: instruction delivered to decode
//  fetch_tid_o      out  TIDW  thread of delivered instruction
//  fetch_pc_o       out  32    dec_pc_o + 4 (mod 2^32)
//  err_o            out  2     sticky: [0] RQ overflow, [1] response with empty tag queue
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): RQ, TQ, RF empty; all outputs 0; err_o=0. Mid-op reset discards all state;
//   imem must be reset in the same cycle.
//  RQ: FIFO {tid,pc,v}, depth NUM_TW_P. Push on sched_vld_i. Full+push -> drop, err_o[0]<=1. Scheduler
//   fetch lock limits outstanding to one per thread, so overflow is a design error.
//  Issue: head valid and credit (TQ count + RF count < RSP_Q_DEPTH_P) -> imem_req_vld_o=1, addr=head pc.
//   Latency sched_vld_i(N) -> imem_req_vld_o(N+1) min. Once asserted, vld/addr held stable until rdy.
//   Fire (vld&rdy) pops RQ, pushes tag {tid,pc,kill} to TQ.
//  Head with v=0 (flushed) popped without request, 1 cycle each.
//  Response: imem_rsp_vld_i pops TQ; kill=0 -> push {tid,pc,instr} to RF; kill=1 -> discard.
//   TQ empty -> ignore, err_o[1]<=1. Credit rule guarantees RF never overflows.
//  Decode: dec_vld_o = RF head valid; payload from head. Fire pops RF; same cycle fetch_done_o=1,
//   fetch_tid_o=dec_tid_o, fetch_pc_o=dec_pc_o+4 (0xFFFFFFFC -> 0). Otherwise fetch_done_o=0.
//  Flush (same cycle, older entries only): RQ entries of tid -> v=0; TQ entries -> kill=1; RF entries
//   removed (masked at head, popped without dec_vld_o). Request held on imem bus stays until accepted,
//   tag pushed with kill=1. Response arriving same cycle as flush for that tid: discarded. sched push of
//   same tid same cycle: NOT flushed. Killed entries never raise fetch_done_o (redirect source unlocks).
//  Simultaneous push/pop on any full FIFO: pop first, push accepted.
// CONFIGURATION
//  MRV1_IFETCH_BYPASS_EN defined: RQ empty and credit available -> sched_pc_i drives imem_req
//   combinationally in cycle N (no RQ write if fired); if not fired, it enqueues normally and
//   stability rule applies from N+1. Undefined: minimum issue latency 1 cycle, no comb path sched->imem.
// TESTING
//  T1 reset: rst_ni=0 2 cycles -> all outputs 0, err_o=0; first sched after release fetches.
//  T2 sched tid=2 pc=0x100, rdy=1, rsp 1 cycle later data=0x13 -> dec {2,0x100,0x13}, fetch_done tid=2 pc=0x104.
//  T3 4 threads issued, imem_req_rdy_i=0 5 cycles -> addr stable; rdy=1 -> requests in issue order, in-order dec.
//  T4 RSP_Q_DEPTH_P=4, dec_rdy_i=0 -> exactly 4 requests fire then imem_req_vld_o=0 until dec_rdy_i=1.
//  T5 tid=3 in flight, flush tid=3 -> its response discarded, no fetch_done; tid=1 unaffected.
//  T6 pc=0xFFFFFFFC -> fetch_pc_o=0; rsp with empty TQ -> err_o[1]=1 sticky until reset.

Source files
------------

// File: rtl/mrv1_ifetch.sv
// mrv1_ifetch: instruction-fetch front end between the IMT scheduler and decode.
// Three FIFOs: request queue (RQ, scheduler issues), tag queue (TQ, requests in
// flight to imem) and response FIFO (RF, instructions waiting for decode).
// Per-thread flush kills older work in all three queues.
// Optional feature: define MRV1_IFETCH_BYPASS_EN to let an issue reach imem in
// the same cycle when RQ is empty and credit is available.
module mrv1_ifetch #(
    parameter int NUM_TW_P      = 8,
    parameter int RSP_Q_DEPTH_P = 4,
    localparam int tid_width_lp = (NUM_TW_P > 1) ? $clog2(NUM_TW_P) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    sched_vld_i,
    input  logic [tid_width_lp-1:0] sched_tid_i,
    input  logic [31:0]             sched_pc_i,
    input  logic                    flush_vld_i,
    input  logic [tid_width_lp-1:0] flush_tid_i,
    output logic                    imem_req_vld_o,
    output logic [31:0]             imem_req_addr_o,
    input  logic                    imem_req_rdy_i,
    input  logic                    imem_rsp_vld_i,
    input  logic [31:0]             imem_rsp_data_i,
    output logic                    dec_vld_o,
    input  logic                    dec_rdy_i,
    output logic [tid_width_lp-1:0] dec_tid_o,
    output logic [31:0]             dec_pc_o,
    output logic [31:0]             dec_instr_o,
    output logic                    fetch_done_o,
    output logic [tid_width_lp-1:0] fetch_tid_o,
    output logic [31:0]             fetch_pc_o,
    output logic [1:0]              err_o
);
    localparam int RQ_PW = tid_width_lp;
    localparam int RQ_CW = $clog2(NUM_TW_P + 1);
    localparam int SQ_PW = (RSP_Q_DEPTH_P > 1) ? $clog2(RSP_Q_DEPTH_P) : 1;
    localparam int SQ_CW = $clog2(RSP_Q_DEPTH_P + 1);

    typedef struct packed {
        logic [tid_width_lp-1:0] tid;
        logic [31:0]             pc;
        logic                    v;
    } rq_ent_t;

    typedef struct packed {
        logic [tid_width_lp-1:0] tid;
        logic [31:0]             pc;
        logic                    kill;
    } tq_ent_t;

    typedef struct packed {
        logic [tid_width_lp-1:0] tid;
        logic [31:0]             pc;
        logic [31:0]             instr;
        logic                    v;
    } rf_ent_t;

    rq_ent_t            rq_mem [NUM_TW_P];
    tq_ent_t            tq_mem [RSP_Q_DEPTH_P];
    rf_ent_t            rf_mem [RSP_Q_DEPTH_P];
    logic [RQ_PW-1:0]   rq_rd, rq_wr;
    logic [RQ_CW-1:0]   rq_cnt;
    logic [SQ_PW-1:0]   tq_rd, tq_wr, rf_rd, rf_wr;
    logic [SQ_CW-1:0]   tq_cnt, rf_cnt;
    logic               req_hold;
    logic [1:0]         err_q;

    rq_ent_t            rq_head;
    tq_ent_t            tq_head, tq_wdata;
    rf_ent_t            rf_head;
    logic               rq_empty, rq_full, credit;
    logic               req_vld, req_fire, req_bypass, rq_skip;
    logic [31:0]        req_addr;
    logic               rq_push, rq_push_ok, rq_pop;
    logic               rsp_take, rsp_keep, rf_flush_head, rf_pop, dec_fire;

    // RQ is sized to NUM_TW_P, which need not be a power of two
    function automatic logic [RQ_PW-1:0] rq_nxt(input logic [RQ_PW-1:0] p);
        return (p == RQ_PW'(NUM_TW_P - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rq_head  = rq_mem[rq_rd];
    assign tq_head  = tq_mem[tq_rd];
    assign rf_head  = rf_mem[rf_rd];
    assign rq_empty = (rq_cnt == '0);
    assign rq_full  = (rq_cnt == RQ_CW'(NUM_TW_P));
    // Every fired request reserves a slot in RF, so RF can never overflow
    assign credit   = (32'(tq_cnt) + 32'(rf_cnt)) < 32'(RSP_Q_DEPTH_P);

    // Request selection: held request first, then RQ head, then optional bypass
    always_comb begin
        req_vld    = 1'b0;
        req_addr   = '0;
        req_bypass = 1'b0;
        rq_skip    = 1'b0;
        if (req_hold) begin
            req_vld  = 1'b1;
            req_addr = rq_head.pc;
        end else if (!rq_empty) begin
            if (!rq_head.v) begin
                rq_skip = 1'b1;
            end else if (credit) begin
                req_vld  = 1'b1;
                req_addr = rq_head.pc;
            end
        end
`ifdef MRV1_IFETCH_BYPASS_EN
        else if (sched_vld_i && credit) begin
            req_vld    = 1'b1;
            req_addr   = sched_pc_i;
            req_bypass = 1'b1;
        end
`endif
    end

    assign req_fire   = req_vld & imem_req_rdy_i;
    assign rq_pop     = (req_fire & ~req_bypass) | rq_skip;
    assign rq_push    = sched_vld_i & ~(req_fire & req_bypass);
    assign rq_push_ok = rq_push & (~rq_full | rq_pop);

    // A bypassed issue is never flushed by a same-cycle flush; a queued one may be
    always_comb begin
        tq_wdata = '0;
        if (req_bypass) begin
            tq_wdata.tid  = sched_tid_i;
            tq_wdata.pc   = sched_pc_i;
            tq_wdata.kill = 1'b0;
        end else begin
            tq_wdata.tid  = rq_head.tid;
            tq_wdata.pc   = rq_head.pc;
            tq_wdata.kill = ~rq_head.v | (flush_vld_i & (flush_tid_i == rq_head.tid));
        end
    end

    assign rsp_take      = imem_rsp_vld_i & (tq_cnt != '0);
    assign rsp_keep      = rsp_take & ~tq_head.kill & ~(flush_vld_i & (flush_tid_i == tq_head.tid));
    assign rf_flush_head = flush_vld_i & (flush_tid_i == rf_head.tid);
    assign dec_vld_o     = (rf_cnt != '0) & rf_head.v & ~rf_flush_head;
    assign dec_fire      = dec_vld_o & dec_rdy_i;
    assign rf_pop        = (rf_cnt != '0) & (dec_fire | ~rf_head.v | rf_flush_head);

    assign imem_req_vld_o  = req_vld;
    assign imem_req_addr_o = req_vld ? req_addr : '0;
    assign dec_tid_o       = dec_vld_o ? rf_head.tid : '0;
    assign dec_pc_o        = dec_vld_o ? rf_head.pc : '0;
    assign dec_instr_o     = dec_vld_o ? rf_head.instr : '0;
    assign fetch_done_o    = dec_fire;
    assign fetch_tid_o     = dec_fire ? rf_head.tid : '0;
    assign fetch_pc_o      = dec_fire ? rf_head.pc + 32'd4 : '0;
    assign err_o           = err_q;

    // Queue storage: flush marks older entries first, then the same-cycle push lands unflushed
    always_ff @(posedge clk_i) begin
        if (flush_vld_i) begin
            for (int i = 0; i < NUM_TW_P; i++)
                if (rq_mem[i].tid == flush_tid_i) rq_mem[i].v <= 1'b0;
            for (int i = 0; i < RSP_Q_DEPTH_P; i++) begin
                if (tq_mem[i].tid == flush_tid_i) tq_mem[i].kill <= 1'b1;
                if (rf_mem[i].tid == flush_tid_i) rf_mem[i].v <= 1'b0;
            end
        end
        if (rq_push_ok) rq_mem[rq_wr] <= '{tid: sched_tid_i, pc: sched_pc_i, v: 1'b1};
        if (req_fire)   tq_mem[tq_wr] <= tq_wdata;
        if (rsp_keep)   rf_mem[rf_wr] <= '{tid: tq_head.tid, pc: tq_head.pc, instr: imem_rsp_data_i, v: 1'b1};
    end

    // Pointers, occupancy counts, bus-hold flag and sticky errors
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rq_rd <= '0; rq_wr <= '0; rq_cnt <= '0;
            tq_rd <= '0; tq_wr <= '0; tq_cnt <= '0;
            rf_rd <= '0; rf_wr <= '0; rf_cnt <= '0;
            req_hold <= 1'b0;
            err_q    <= '0;
        end else begin
            if (rq_pop)     rq_rd <= rq_nxt(rq_rd);
            if (rq_push_ok) rq_wr <= rq_nxt(rq_wr);
            rq_cnt <= rq_cnt + RQ_CW'(rq_push_ok) - RQ_CW'(rq_pop);
            if (rsp_take)   tq_rd <= tq_rd + 1'b1;
            if (req_fire)   tq_wr <= tq_wr + 1'b1;
            tq_cnt <= tq_cnt + SQ_CW'(req_fire) - SQ_CW'(rsp_take);
            if (rf_pop)     rf_rd <= rf_rd + 1'b1;
            if (rsp_keep)   rf_wr <= rf_wr + 1'b1;
            rf_cnt <= rf_cnt + SQ_CW'(rsp_keep) - SQ_CW'(rf_pop);
            req_hold <= req_vld & ~imem_req_rdy_i;
            if (rq_push & ~rq_push_ok)           err_q[0] <= 1'b1;
            if (imem_rsp_vld_i && tq_cnt == '0)  err_q[1] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mrv1_ifetch.sv
// Scoreboard bench for mrv1_ifetch: issues go into an expected queue in issue
// order; flush marks older entries of a thread as killed; an independent
// monitor pops and compares every instruction handed to decode.
module tb_mrv1_ifetch;
    localparam int NTW = 8;
    localparam int TW  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sched_vld = 1'b0;
    logic [TW-1:0] sched_tid = '0;
    logic [31:0]   sched_pc = '0;
    logic          flush_vld = 1'b0;
    logic [TW-1:0] flush_tid = '0;
    logic          req_vld;
    logic [31:0]   req_addr;
    logic          req_rdy = 1'b0;
    logic          rsp_vld = 1'b0;
    logic [31:0]   rsp_data = '0;
    logic          dec_vld;
    logic          dec_rdy = 1'b0;
    logic [TW-1:0] dec_tid;
    logic [31:0]   dec_pc, dec_instr;
    logic          fetch_done;
    logic [TW-1:0] fetch_tid;
    logic [31:0]   fetch_pc;
    logic [1:0]    err;

    always #5 clk = ~clk;

    mrv1_ifetch #(.NUM_TW_P(NTW), .RSP_Q_DEPTH_P(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .sched_vld_i(sched_vld), .sched_tid_i(sched_tid), .sched_pc_i(sched_pc),
        .flush_vld_i(flush_vld), .flush_tid_i(flush_tid),
        .imem_req_vld_o(req_vld), .imem_req_addr_o(req_addr), .imem_req_rdy_i(req_rdy),
        .imem_rsp_vld_i(rsp_vld), .imem_rsp_data_i(rsp_data),
        .dec_vld_o(dec_vld), .dec_rdy_i(dec_rdy),
        .dec_tid_o(dec_tid), .dec_pc_o(dec_pc), .dec_instr_o(dec_instr),
        .fetch_done_o(fetch_done), .fetch_tid_o(fetch_tid), .fetch_pc_o(fetch_pc),
        .err_o(err)
    );

    typedef struct {
        logic [TW-1:0] tid;
        logic [31:0]   pc;
        bit            killed;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    int          checks = 0, errors = 0, fire_cnt = 0;
    int          rdy_pct = 100, rsp_pct = 100, dec_pct = 100;
    bit          inj_rsp = 1'b0;
    logic [31:0] last_fetch_pc = 32'h1;

    // Memory contents: a fixed hash of the address
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (exp_q[i]) if (!exp_q[i].killed) n++;
        return n;
    endfunction

    function automatic bit locked(input logic [TW-1:0] t);
        foreach (exp_q[i]) if (exp_q[i].tid == t && !exp_q[i].killed) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // One cycle: drive memory response and random handshakes just after the edge
    task automatic step();
        @(posedge clk); #1;
        sched_vld = 1'b0;
        flush_vld = 1'b0;
        rsp_vld   = 1'b0;
        if (inj_rsp) begin
            rsp_vld  = 1'b1;
            rsp_data = 32'hDEAD_BEEF;
            inj_rsp  = 1'b0;
        end else if (mem_q.size() > 0 && int'($urandom_range(0, 99)) < rsp_pct) begin
            rsp_vld  = 1'b1;
            rsp_data = instr_of(mem_q.pop_front());
        end
        req_rdy = int'($urandom_range(0, 99)) < rdy_pct;
        dec_rdy = int'($urandom_range(0, 99)) < dec_pct;
    endtask

    task automatic issue(input logic [TW-1:0] t, input logic [31:0] pc);
        exp_t e;
        sched_vld = 1'b1;
        sched_tid = t;
        sched_pc  = pc;
        e.tid = t; e.pc = pc; e.killed = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic flush(input logic [TW-1:0] t);
        flush_vld = 1'b1;
        flush_tid = t;
        foreach (exp_q[i]) if (exp_q[i].tid == t) exp_q[i].killed = 1'b1;
    endtask

    task automatic drain(input string name, input int n);
        rdy_pct = 100; rsp_pct = 100; dec_pct = 100;
        repeat (n) step();
        @(negedge clk);
        check(name, 64'(live_cnt()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_n = 1'b0; sched_vld = 1'b0; flush_vld = 1'b0; rsp_vld = 1'b0; inj_rsp = 1'b0;
        mem_q.delete();
        exp_q.delete();
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // imem side: record fired requests, and hold stalled requests to stability
    initial begin
        bit          stall = 1'b0;
        logic [31:0] addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    checks++;
                    if (!(req_vld && req_addr == addr)) begin
                        errors++;
                        $display("FAIL req_stable got vld=%0b addr=%h want vld=1 addr=%h", req_vld, req_addr, addr);
                    end
                end
                if (req_vld && req_rdy) begin
                    mem_q.push_back(req_addr);
                    fire_cnt++;
                end
                stall = req_vld && !req_rdy;
                addr  = req_addr;
            end
        end
    end

    // Decode monitor: every delivery must be the oldest live issue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (fetch_done || (dec_vld && dec_rdy))) begin
                checks++;
                if (!(fetch_done && dec_vld && dec_rdy)) begin
                    errors++;
                    $display("FAIL fetch_done_pulse got done=%0b fire=%0b want equal", fetch_done, dec_vld && dec_rdy);
                end
            end
            if (rst_n && dec_vld && dec_rdy) begin
                while (exp_q.size() > 0 && exp_q[0].killed) void'(exp_q.pop_front());
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dec_unexpected got tid=%0d pc=%h want none", dec_tid, dec_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (dec_tid !== e.tid || dec_pc !== e.pc || dec_instr !== instr_of(e.pc)) begin
                        errors++;
                        $display("FAIL dec_payload got %0d/%h/%h want %0d/%h/%h",
                                 dec_tid, dec_pc, dec_instr, e.tid, e.pc, instr_of(e.pc));
                    end
                    checks++;
                    if (fetch_tid !== e.tid || fetch_pc !== e.pc + 32'd4) begin
                        errors++;
                        $display("FAIL fetch_info got %0d/%h want %0d/%h", fetch_tid, fetch_pc, e.tid, e.pc + 32'd4);
                    end
                    last_fetch_pc = fetch_pc;
                end
            end
        end
    end

    initial begin
        int            base;
        logic [TW-1:0] t;
        // T1: reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 64'({req_vld, req_addr, dec_vld, fetch_done, fetch_pc}), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // T2: single fetch, minimum issue latency
        step();
        issue(3'd2, 32'h100);
        @(negedge clk);
        check("t2_no_req_same_cycle", 64'(req_vld), 64'd0);
        step();
        @(negedge clk);
        check("t2_req_next_cycle", 64'({req_vld, req_addr}), {31'd0, 1'b1, 32'h100});
        drain("t2_delivered", 8);

        // T3: stalled imem keeps address stable, then order preserved
        rdy_pct = 0;
        step(); issue(3'd0, 32'h1000);
        step(); issue(3'd1, 32'h2000);
        step(); issue(3'd4, 32'h3000);
        step(); issue(3'd5, 32'h4000);
        repeat (5) step();
        @(negedge clk);
        check("t3_held_addr", 64'({req_vld, req_addr}), {31'd0, 1'b1, 32'h1000});
        drain("t3_delivered", 30);

        // T4: credit limit with decode blocked
        dec_pct = 0;
        base = fire_cnt;
        for (int i = 0; i < 6; i++) begin
            step();
            issue(3'(i), 32'h5000 + 32'(i) * 32'h10);
        end
        repeat (10) step();
        @(negedge clk);
        check("t4_fires", 64'(fire_cnt - base), 64'd4);
        check("t4_no_req", 64'(req_vld), 64'd0);
        drain("t4_delivered", 30);

        // T5: flush of an in-flight thread
        rsp_pct = 0;
        step(); issue(3'd3, 32'h3300);
        step(); issue(3'd1, 32'h1100);
        repeat (4) step();
        step(); flush(3'd3);
        drain("t5_delivered", 20);

        // Randomized traffic with periodic quiesce points
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                rdy_pct = int'($urandom_range(30, 100));
                rsp_pct = int'($urandom_range(30, 100));
                dec_pct = int'($urandom_range(30, 100));
            end
            step();
            if ($urandom_range(0, 99) < 8) begin
                t = 3'($urandom_range(0, NTW - 1));
                flush(t);
            end
            if ($urandom_range(0, 99) < 50 && exp_q.size() < NTW) begin
                t = 3'($urandom_range(0, NTW - 1));
                if (!locked(t)) issue(t, $urandom() & 32'hFFFF_FFFC);
            end
            if (c % 500 == 499) drain("rand_delivered", 60);
        end
        check("rand_no_err", 64'(err), 64'd0);

        // T6: PC wrap, then response with nothing outstanding
        step(); issue(3'd7, 32'hFFFF_FFFC);
        drain("t6_delivered", 10);
        check("t6_pc_wrap", 64'(last_fetch_pc), 64'd0);
        inj_rsp = 1'b1;
        step();
        step();
        @(negedge clk);
        check("t6_err_rsp", 64'(err), 64'd2);
        repeat (5) step();
        @(negedge clk);
        check("t6_err_sticky", 64'(err), 64'd2);
        do_reset(2);
        @(negedge clk);
        check("t6_err_cleared", 64'(err), 64'd0);
        step(); issue(3'd6, 32'h600);
        drain("post_reset_fetch", 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
